// File: rtl/tx_crc_serializer.sv
// -----------------------------------------------------------------------------
// tx_crc_serializer
//
// Purpose:
//   Takes the assembled 136-bit TX packet from the input register stage and
//   sends it as a serial frame, MSB-first: 8 header bits, N payload bytes
//   (N = len + 1), then a CRC-8 byte computed over header + payload.
//   When test_mode is captured high, the LSB of the CRC byte is inverted so
//   the receiver's error path can be exercised.
//
// Ports:
//   clk         in   1    system clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start_n     in   1    active-low send button, asynchronous to clk
//   tx_packet   in   136  [135:134] dest, [133:132] src, [131:128] len,
//                        [127:0] payload (byte0 at [127:120])
//   test_mode   in   1    1 = corrupt the transmitted CRC
//   flag_status in   2    [1] header done, [0] data done
//   tx_out      out  1    serial data, idles high
//   tx_active   out  1    high for every bit period of a frame
//   tx_done     out  1    one-cycle pulse after the last CRC bit period
//   busy        out  1    high from start acceptance until tx_done
//   reject      out  1    one-cycle pulse when a start edge is refused
//   crc_out     out  8    CRC byte sent in the last frame (after corruption)
// -----------------------------------------------------------------------------
module tx_crc_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  CRC_POLY     = 8'h07
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_n,
  input  logic [135:0] tx_packet,
  input  logic         test_mode,
  input  logic [1:0]   flag_status,
  output logic         tx_out,
  output logic         tx_active,
  output logic         tx_done,
  output logic         busy,
  output logic         reject,
  output logic [7:0]   crc_out
);

  // Width of the per-bit cycle counter; at least one bit so CLKS_PER_BIT=1
  // still gives a legal vector.
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;

  logic             start_meta_q;
  logic             start_sync_q;
  logic             start_prev_q;
  logic             start_pulse;

  logic [135:0]     shift_q, shift_d;
  logic             tm_q, tm_d;
  logic [7:0]       send_bits_q, send_bits_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       crc_shift_q, crc_shift_d;
  logic [7:0]       crc_out_q, crc_out_d;

  logic             bit_end;
  logic [7:0]       crc_next;
  logic [7:0]       crc_final;

  // One step of the serial CRC-8: feedback is the outgoing MSB XOR data bit.
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  // Button synchronizer. Reset to the released level (high) so leaving reset
  // with the button up never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta_q <= 1'b1;
      start_sync_q <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      start_meta_q <= start_n;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  // Press = high-to-low transition of the synchronized button.
  assign start_pulse = start_prev_q & ~start_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      tm_q        <= 1'b0;
      send_bits_q <= '0;
      bit_cnt_q   <= '0;
      clk_cnt_q   <= '0;
      crc_q       <= '0;
      crc_shift_q <= '0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tm_q        <= tm_d;
      send_bits_q <= send_bits_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_cnt_q   <= clk_cnt_d;
      crc_q       <= crc_d;
      crc_shift_q <= crc_shift_d;
      crc_out_q   <= crc_out_d;
    end
  end

  assign bit_end   = (clk_cnt_q == CNT_LAST);
  // The bit currently on the line is always the MSB of the shadow shifter.
  assign crc_next  = crc_step(crc_q, shift_q[135]);
  assign crc_final = crc_next ^ {7'b0, tm_q};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tm_d        = tm_q;
    send_bits_d = send_bits_q;
    bit_cnt_d   = bit_cnt_q;
    clk_cnt_d   = clk_cnt_q;
    crc_d       = crc_q;
    crc_shift_d = crc_shift_q;
    crc_out_d   = crc_out_q;
    tx_out      = 1'b1;
    tx_active   = 1'b0;
    busy        = 1'b0;
    tx_done     = 1'b0;
    reject      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          if (flag_status == 2'b11) begin
            shift_d     = tx_packet;
            tm_d        = test_mode;
            // Header + payload bits = 8 + 8*(len+1) = 8*len + 16 (16..136).
            send_bits_d = {1'b0, tx_packet[131:128], 3'b000} + 8'd16;
            bit_cnt_d   = '0;
            clk_cnt_d   = '0;
            crc_d       = '0;
            state_d     = ST_SEND;
          end else begin
            reject = 1'b1;
          end
        end
      end

      ST_SEND: begin
        tx_out    = shift_q[135];
        tx_active = 1'b1;
        busy      = 1'b1;
        reject    = start_pulse;
        if (bit_end) begin
          clk_cnt_d = '0;
          crc_d     = crc_next;
          shift_d   = {shift_q[134:0], 1'b0};
          if (bit_cnt_q == send_bits_q - 8'd1) begin
            // Last payload bit done: latch the (possibly corrupted) CRC for
            // both the line and the crc_out report.
            bit_cnt_d   = '0;
            crc_shift_d = crc_final;
            crc_out_d   = crc_final;
            state_d     = ST_CRC;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_CRC: begin
        tx_out    = crc_shift_q[7];
        tx_active = 1'b1;
        busy      = 1'b1;
        reject    = start_pulse;
        if (bit_end) begin
          clk_cnt_d   = '0;
          crc_shift_d = {crc_shift_q[6:0], 1'b0};
          if (bit_cnt_q == 8'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        tx_done = 1'b1;
        // A press landing in this cycle is refused; the next frame must
        // start from IDLE.
        reject  = start_pulse;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign crc_out = crc_out_q;

endmodule

// File: doc/tx_crc_serializer.md
Name: tx_crc_serializer

Overview:
- Downstream neighbour of the TX input register ("mouth" stage).
- Consumes the 136-bit assembled packet, the test_mode bit and the header/data-done flags.
- Computes CRC-8 over header + payload and shifts the frame out serially, MSB-first, appending the CRC byte.
- In test mode it corrupts the CRC so the receiver's error path can be exercised.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (must be >= 1).
- CRC_POLY, 8'h07, CRC-8 generator polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; driven by the input register's rst_out_n.
- start_n  input  1  active-low send button (KEY1), asynchronous to clk.
- tx_packet  input  136  [135:134] dest, [133:132] src, [131:128] len, [127:0] payload bytes (byte0 at [127:120]).
- test_mode  input  1  1 = inject CRC error.
- flag_status  input  2  [1] header done, [0] data done.
- tx_out  output  1  serial data; idles high.
- tx_active  output  1  high for every bit period of a frame.
- tx_done  output  1  one-cycle pulse after the last CRC bit period ends.
- busy  output  1  high from start acceptance until tx_done.
- reject  output  1  one-cycle pulse when a start edge is refused.
- crc_out  output  8  CRC value transmitted in the last frame (after any test-mode corruption).

Behaviour:
- Reset (async, rst_n=0): tx_out=1, tx_active=0, tx_done=0, busy=0, reject=0, crc_out=8'h00, FSM=IDLE, all counters and shadow regs zero. Deassertion mid-frame aborts the frame; there is no resume.
- start_n path: 2-flop synchronizer, then falling-edge detector → start_pulse, 1 cycle.
- Start acceptance: start_pulse in IDLE with flag_status==2'b11.
  - Capture tx_packet and test_mode into shadow registers; later input changes do not affect the frame.
  - Set busy, go to SEND.
- Start refusal: start_pulse in IDLE with flags != 2'b11, or start_pulse in any non-IDLE state → reject pulses, state unchanged.
- Payload byte count: N = len + 1 (1..16), matching the upstream data-done rule.
- Frame bit count: F = 8 header + 8N payload + 8 CRC (24..144). Bit counter is 8 bits wide.
- FSM states:
  - IDLE: tx_out=1, tx_active=0.
  - SEND: first cycle after acceptance; drives shadow bit 135 down to bit (128 - 8N).
    - Each bit is held CLKS_PER_BIT cycles, tx_active=1.
    - At the end of each bit period, update the CRC: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
    - After the last payload bit, go to CRC.
  - CRC: on entry, final = crc ^ {7'b0, test_mode_shadow}; crc_out <= final.
    - Shift out final MSB-first, 8 bit periods.
    - Then go to DONE.
  - DONE: one cycle; tx_done=1, busy=0, tx_out=1, tx_active=0; then go to IDLE.
- Back-to-back frames: a start_pulse in the DONE cycle is rejected. The next frame is accepted from IDLE.
- Frame timing: a frame occupies exactly F*CLKS_PER_BIT cycles of tx_active. tx_done follows the last tx_active cycle by one cycle.
- Unused payload bits beyond N bytes are never transmitted.

Test Plan:
- Reset idle: rst_n low then high, no start → tx_out=1, tx_active=0, busy=0, crc_out=0.
- Basic frame (CLKS_PER_BIT=4): flags=11, tx_packet[135:120]=16'h4000, test_mode=0, start_n falls → bits 0x40,0x00,0x5B on tx_out MSB-first; tx_active high 96 cycles; tx_done one pulse; crc_out=8'h5B.
- Test mode: same stimulus with test_mode=1 → CRC byte 0x5A, crc_out=8'h5A, payload bits unchanged.
- Not ready: flags=2'b10, start_n falls → reject pulses once, tx_active stays 0, busy stays 0.
- Max length and refusal: len=4'hF, 16 payload bytes, start pressed again mid-frame → 144 bit periods sent; second press gives reject only; tx_packet changed mid-frame does not alter the frame.
- Reset mid-frame: rst_n low during SEND → tx_out=1 and busy=0 immediately (async); after release, a new start sends a correct full frame.
